// File: rtl/generic_cache_pkg.sv
// Shared parameters, derived address-field widths, state encoding and line type
// for the generic_cache block.
package generic_cache_pkg;
    localparam int W        = 64;
    localparam int C        = 8192;
    localparam int B        = 64;
    localparam int A        = 2;
    localparam int LINE_W   = B * 8;
    localparam int SETS     = C / (B * A);
    localparam int OFFSET_W = $clog2(B);
    localparam int INDEX_W  = $clog2(SETS);
    localparam int TAG_W    = W - OFFSET_W - INDEX_W;
    localparam int BYTE_W   = $clog2(W / 8);
    localparam int WSEL_W   = $clog2(LINE_W / W);
    localparam int WAY_W    = $clog2(A);

    typedef enum logic [2:0] {
        IDLE,
        RESP,
        WB,
        FILL_REQ,
        FILL_WAIT,
        FLUSH
    } state_t;

    typedef logic [LINE_W-1:0] line_t;
endpackage

// File: rtl/generic_cache_tag_array.sv
// Valid/dirty/tag/LRU storage with combinational hit and victim lookup.
// Victim is the lowest invalid way, otherwise the LRU way (one LRU bit per set, 2 ways).
module cache_tag_array
    import generic_cache_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [INDEX_W-1:0] i_lk_index,
    input  logic [TAG_W-1:0]   i_lk_tag,
    output logic               o_hit,
    output logic [WAY_W-1:0]   o_hit_way,
    output logic [WAY_W-1:0]   o_victim_way,
    output logic               o_victim_dirty,
    input  logic [INDEX_W-1:0] i_rd_index,
    input  logic [WAY_W-1:0]   i_rd_way,
    output logic               o_rd_valid,
    output logic               o_rd_dirty,
    output logic [TAG_W-1:0]   o_rd_tag,
    input  logic [INDEX_W-1:0] i_wr_index,
    input  logic [WAY_W-1:0]   i_wr_way,
    input  logic               i_touch,
    input  logic               i_install,
    input  logic [TAG_W-1:0]   i_install_tag,
    input  logic               i_install_dirty,
    input  logic               i_mark_dirty,
    input  logic               i_inval_all
);
    logic [A-1:0]     r_valid [SETS];
    logic [A-1:0]     r_dirty [SETS];
    logic [WAY_W-1:0] r_lru   [SETS];
    logic [TAG_W-1:0] r_tag   [SETS][A];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_lru[s]   <= '0;
            end
        end else if (i_inval_all) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
        end else begin
            if (i_install) begin
                r_valid[i_wr_index][i_wr_way] <= 1'b1;
                r_dirty[i_wr_index][i_wr_way] <= i_install_dirty;
            end else if (i_mark_dirty) begin
                r_dirty[i_wr_index][i_wr_way] <= 1'b1;
            end
            // r_lru holds the least recently used way, i.e. the one not touched
            if (i_touch) begin
                r_lru[i_wr_index] <= ~i_wr_way;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (i_install) begin
            r_tag[i_wr_index][i_wr_way] <= i_install_tag;
        end
    end

    always_comb begin
        o_hit        = 1'b0;
        o_hit_way    = '0;
        o_victim_way = r_lru[i_lk_index];
        for (int w = 0; w < A; w++) begin
            if (r_valid[i_lk_index][w] && (r_tag[i_lk_index][w] == i_lk_tag)) begin
                o_hit     = 1'b1;
                o_hit_way = WAY_W'(w);
            end
        end
        for (int w = A - 1; w >= 0; w--) begin
            if (!r_valid[i_lk_index][w]) begin
                o_victim_way = WAY_W'(w);
            end
        end
        o_victim_dirty = r_valid[i_lk_index][o_victim_way] && r_dirty[i_lk_index][o_victim_way];
    end

    assign o_rd_valid = r_valid[i_rd_index][i_rd_way];
    assign o_rd_dirty = r_dirty[i_rd_index][i_rd_way];
    assign o_rd_tag   = r_tag[i_rd_index][i_rd_way];
endmodule

// File: rtl/generic_cache.sv
// Set-associative write-back/write-allocate cache, one request in flight.
// IDLE: accept/lookup | RESP: hold response | WB: victim write-back | FILL_REQ: line read | FILL_WAIT: await fill | FLUSH: walk and clean
module generic_cache
    import generic_cache_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_N_in,
    input  logic              cs_in,
    input  logic              flush_in,
    input  logic              hc_valid_in,
    output logic              hc_ready_out,
    input  logic [W-1:0]      hc_addr_in,
    input  logic [W-1:0]      hc_value_in,
    input  logic              hc_we_in,
    output logic              hc_valid_out,
    input  logic              hc_ready_in,
    output logic              hc_we_out,
    output logic [W-1:0]      hc_addr_out,
    output logic [W-1:0]      hc_value_out,
    output logic              lc_valid_out,
    input  logic              lc_ready_in,
    output logic [W-1:0]      lc_addr_out,
    output logic [LINE_W-1:0] lc_value_out,
    output logic              we_out,
    input  logic              lc_valid_in,
    output logic              lc_ready_out,
    input  logic [W-1:0]      lc_addr_in,
    input  logic [W-1:0]      lc_value_in,
    input  logic              cl_in,
    input  logic [LINE_W-1:0] cache_line_in
);
    state_t                   r_state, w_next;
    logic [W-1:0]             r_pend_addr, r_pend_value, r_resp_value;
    logic                     r_pend_we;
    logic [WAY_W-1:0]         r_pend_way;
    logic [INDEX_W+WAY_W-1:0] r_flush_cnt;
    line_t                    r_data [SETS][A];

    logic [INDEX_W-1:0] w_idx, w_p_idx, w_rd_idx, w_wr_idx;
    logic [TAG_W-1:0]   w_tag, w_p_tag, w_rd_tag;
    logic [WSEL_W-1:0]  w_wsel, w_p_wsel, w_fill_wsel;
    logic [WAY_W-1:0]   w_hit_way, w_victim_way, w_rd_way, w_wr_way;
    logic               w_hit, w_victim_dirty, w_rd_valid, w_rd_dirty;
    logic               w_accept, w_fill, w_hit_store, w_flush_wb, w_flush_step, w_flush_done;
    logic [W-1:0]       w_hit_word;
    line_t              w_fill_line, w_rd_line;
    logic               w_unused;

    assign w_idx       = hc_addr_in[OFFSET_W +: INDEX_W];
    assign w_tag       = hc_addr_in[OFFSET_W+INDEX_W +: TAG_W];
    assign w_wsel      = hc_addr_in[BYTE_W +: WSEL_W];
    assign w_p_idx     = r_pend_addr[OFFSET_W +: INDEX_W];
    assign w_p_tag     = r_pend_addr[OFFSET_W+INDEX_W +: TAG_W];
    assign w_p_wsel    = r_pend_addr[BYTE_W +: WSEL_W];
    assign w_fill_wsel = lc_addr_in[BYTE_W +: WSEL_W];
    assign w_unused    = ^{lc_addr_in[W-1:OFFSET_W], lc_addr_in[BYTE_W-1:0]};

    assign w_accept     = hc_valid_in && hc_ready_out;
    assign w_fill       = (r_state == FILL_WAIT) && lc_valid_in;
    assign w_hit_store  = w_accept && w_hit && hc_we_in;
    assign w_rd_idx     = (r_state == FLUSH) ? r_flush_cnt[WAY_W +: INDEX_W] : w_p_idx;
    assign w_rd_way     = (r_state == FLUSH) ? r_flush_cnt[WAY_W-1:0] : r_pend_way;
    assign w_rd_line    = r_data[w_rd_idx][w_rd_way];
    assign w_hit_word   = r_data[w_idx][w_hit_way][w_wsel*W +: W];
    assign w_flush_wb   = (r_state == FLUSH) && w_rd_valid && w_rd_dirty;
    assign w_flush_step = (r_state == FLUSH) && (!w_flush_wb || lc_ready_in);
    assign w_flush_done = w_flush_step && (r_flush_cnt == '0);
    assign w_wr_idx     = w_fill ? w_p_idx : w_idx;
    assign w_wr_way     = w_fill ? r_pend_way : w_hit_way;

    // Replayed store is merged over the incoming fill before install
    always_comb begin
        w_fill_line = cl_in ? cache_line_in : '0;
        if (!cl_in) begin
            w_fill_line[w_fill_wsel*W +: W] = lc_value_in;
        end
        if (r_pend_we) begin
            w_fill_line[w_p_wsel*W +: W] = r_pend_value;
        end
    end

    cache_tag_array u_tags (
        .clk_in          (clk_in),
        .rst_in          (rst_N_in),
        .i_lk_index      (w_idx),
        .i_lk_tag        (w_tag),
        .o_hit           (w_hit),
        .o_hit_way       (w_hit_way),
        .o_victim_way    (w_victim_way),
        .o_victim_dirty  (w_victim_dirty),
        .i_rd_index      (w_rd_idx),
        .i_rd_way        (w_rd_way),
        .o_rd_valid      (w_rd_valid),
        .o_rd_dirty      (w_rd_dirty),
        .o_rd_tag        (w_rd_tag),
        .i_wr_index      (w_wr_idx),
        .i_wr_way        (w_wr_way),
        .i_touch         ((w_accept && w_hit) || w_fill),
        .i_install       (w_fill),
        .i_install_tag   (w_p_tag),
        .i_install_dirty (r_pend_we),
        .i_mark_dirty    (w_hit_store),
        .i_inval_all     (w_flush_done)
    );

    always_ff @(posedge clk_in or posedge rst_N_in) begin
        if (rst_N_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (flush_in) begin
                    w_next = FLUSH;
                end else if (w_accept) begin
                    w_next = w_hit ? RESP : (w_victim_dirty ? WB : FILL_REQ);
                end
            end
            RESP:      if (hc_ready_in) w_next = IDLE;
            WB:        if (lc_ready_in) w_next = FILL_REQ;
            FILL_REQ:  if (lc_ready_in) w_next = FILL_WAIT;
            FILL_WAIT: if (lc_valid_in) w_next = RESP;
            FLUSH:     if (w_flush_done) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        hc_ready_out = 1'b0;
        hc_valid_out = 1'b0;
        lc_valid_out = 1'b0;
        we_out       = 1'b0;
        lc_addr_out  = '0;
        lc_value_out = '0;
        lc_ready_out = 1'b0;
        case (r_state)
            IDLE:      hc_ready_out = !rst_N_in && cs_in && !flush_in;
            RESP:      hc_valid_out = 1'b1;
            WB: begin
                lc_valid_out = 1'b1;
                we_out       = 1'b1;
                lc_addr_out  = {w_rd_tag, w_rd_idx, {OFFSET_W{1'b0}}};
                lc_value_out = w_rd_line;
            end
            FILL_REQ: begin
                lc_valid_out = 1'b1;
                lc_addr_out  = {w_p_tag, w_p_idx, {OFFSET_W{1'b0}}};
            end
            FILL_WAIT: lc_ready_out = 1'b1;
            FLUSH: begin
                if (w_flush_wb) begin
                    lc_valid_out = 1'b1;
                    we_out       = 1'b1;
                    lc_addr_out  = {w_rd_tag, w_rd_idx, {OFFSET_W{1'b0}}};
                    lc_value_out = w_rd_line;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (w_fill) begin
            r_data[w_p_idx][r_pend_way] <= w_fill_line;
        end else if (w_hit_store) begin
            r_data[w_idx][w_hit_way][w_wsel*W +: W] <= hc_value_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_N_in) begin
        if (rst_N_in) begin
            r_pend_addr  <= '0;
            r_pend_value <= '0;
            r_pend_we    <= 1'b0;
            r_pend_way   <= '0;
            r_resp_value <= '0;
            r_flush_cnt  <= '1;
        end else begin
            if (w_accept) begin
                r_pend_addr  <= hc_addr_in;
                r_pend_value <= hc_value_in;
                r_pend_we    <= hc_we_in;
                r_pend_way   <= w_hit ? w_hit_way : w_victim_way;
                if (w_hit) begin
                    r_resp_value <= hc_we_in ? hc_value_in : w_hit_word;
                end
            end
            if (w_fill) begin
                r_resp_value <= w_fill_line[w_p_wsel*W +: W];
            end
            if (r_state == IDLE) begin
                r_flush_cnt <= '1;
            end else if (w_flush_step) begin
                r_flush_cnt <= r_flush_cnt - 1'b1;
            end
        end
    end

    assign hc_we_out    = r_pend_we;
    assign hc_addr_out  = r_pend_addr;
    assign hc_value_out = r_resp_value;
endmodule

// File: tb/tb_generic_cache.sv
// Scoreboard bench for generic_cache: expected responses are queued at issue
// and compared by a monitor when the cache answers.
module tb_generic_cache;
    logic         clk_in = 1'b0;
    logic         rst_N_in;
    logic         cs_in, flush_in;
    logic         hc_valid_in, hc_ready_out, hc_we_in;
    logic [63:0]  hc_addr_in, hc_value_in;
    logic         hc_valid_out, hc_ready_in, hc_we_out;
    logic [63:0]  hc_addr_out, hc_value_out;
    logic         lc_valid_out, lc_ready_in, we_out;
    logic [63:0]  lc_addr_out;
    logic [511:0] lc_value_out;
    logic         lc_valid_in, lc_ready_out, cl_in;
    logic [63:0]  lc_addr_in, lc_value_in;
    logic [511:0] cache_line_in;

    typedef struct packed {
        logic [63:0] addr;
        logic        we;
        logic [63:0] value;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk_in = ~clk_in;

    generic_cache dut (
        .clk_in        (clk_in),
        .rst_N_in      (rst_N_in),
        .cs_in         (cs_in),
        .flush_in      (flush_in),
        .hc_valid_in   (hc_valid_in),
        .hc_ready_out  (hc_ready_out),
        .hc_addr_in    (hc_addr_in),
        .hc_value_in   (hc_value_in),
        .hc_we_in      (hc_we_in),
        .hc_valid_out  (hc_valid_out),
        .hc_ready_in   (hc_ready_in),
        .hc_we_out     (hc_we_out),
        .hc_addr_out   (hc_addr_out),
        .hc_value_out  (hc_value_out),
        .lc_valid_out  (lc_valid_out),
        .lc_ready_in   (lc_ready_in),
        .lc_addr_out   (lc_addr_out),
        .lc_value_out  (lc_value_out),
        .we_out        (we_out),
        .lc_valid_in   (lc_valid_in),
        .lc_ready_out  (lc_ready_out),
        .lc_addr_in    (lc_addr_in),
        .lc_value_in   (lc_value_in),
        .cl_in         (cl_in),
        .cache_line_in (cache_line_in)
    );

    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mk_line(input logic [63:0] base);
        logic [511:0] l;
        for (int i = 0; i < 8; i++) l[i*64 +: 64] = base + 64'(i);
        return l;
    endfunction

    always @(negedge clk_in) begin
        if (!rst_N_in && hc_valid_out && hc_ready_in) begin
            check_eq("resp_expected", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check_eq("resp_value", hc_value_out, mon_e.value);
                check_eq("resp_addr", hc_addr_out, mon_e.addr);
                check_eq("resp_we", hc_we_out, mon_e.we);
            end
        end
    end

    task automatic issue(input logic [63:0] addr, input logic we, input logic [63:0] value,
                         input logic [63:0] exp_val, input logic exp_miss, input string tag);
        int guard = 0;
        @(negedge clk_in);
        hc_valid_in = 1'b1;
        hc_addr_in  = addr;
        hc_we_in    = we;
        hc_value_in = value;
        while (!hc_ready_out && guard < 50) begin
            @(negedge clk_in);
            guard++;
        end
        check_eq({tag, "_ready"}, hc_ready_out, 1'b1);
        sb_q.push_back('{addr: addr, we: we, value: exp_val});
        @(posedge clk_in);
        #1;
        hc_valid_in = 1'b0;
        check_eq({tag, "_lc_valid_at_accept"}, lc_valid_out, exp_miss);
        check_eq({tag, "_hc_valid_at_accept"}, hc_valid_out, !exp_miss);
    endtask

    task automatic lc_req(input logic exp_we, input logic [63:0] exp_addr, input int wsel,
                          input logic [63:0] exp_word, input string tag);
        int guard = 0;
        @(negedge clk_in);
        while (!lc_valid_out && guard < 300) begin
            @(negedge clk_in);
            guard++;
        end
        check_eq({tag, "_lc_req"}, lc_valid_out, 1'b1);
        check_eq({tag, "_we_out"}, we_out, exp_we);
        check_eq({tag, "_lc_addr"}, lc_addr_out, exp_addr);
        if (exp_we) check_eq({tag, "_wb_word"}, lc_value_out[wsel*64 +: 64], exp_word);
        else        check_eq({tag, "_rd_value_zero"}, lc_value_out, '0);
        lc_ready_in = 1'b1;
        @(posedge clk_in);
        #1;
        lc_ready_in = 1'b0;
    endtask

    task automatic fill(input logic [63:0] addr, input logic [63:0] value, input logic cl,
                        input logic [511:0] line, input string tag);
        int guard = 0;
        @(negedge clk_in);
        while (!lc_ready_out && guard < 50) begin
            @(negedge clk_in);
            guard++;
        end
        check_eq({tag, "_fill_ready"}, lc_ready_out, 1'b1);
        lc_valid_in   = 1'b1;
        lc_addr_in    = addr;
        lc_value_in   = value;
        cl_in         = cl;
        cache_line_in = line;
        @(posedge clk_in);
        #1;
        lc_valid_in = 1'b0;
        cl_in       = 1'b0;
        check_eq({tag, "_resp_at_fill"}, hc_valid_out, 1'b1);
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (sb_q.size() != 0 && guard < 50) begin
            @(negedge clk_in);
            guard++;
        end
        check_eq({tag, "_drained"}, sb_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctrl"}, {hc_ready_out, hc_valid_out, hc_we_out, lc_valid_out, we_out, lc_ready_out}, '0);
        check_eq({tag, "_hc_data"}, {hc_addr_out, hc_value_out}, '0);
        check_eq({tag, "_lc_addr"}, lc_addr_out, '0);
        check_eq({tag, "_lc_value"}, lc_value_out, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst_N_in = 1'b1;
        cs_in = 1'b1;   flush_in = 1'b0;
        hc_valid_in = 1'b0; hc_we_in = 1'b0; hc_addr_in = '0; hc_value_in = '0;
        hc_ready_in = 1'b1; lc_ready_in = 1'b0;
        lc_valid_in = 1'b0; lc_addr_in = '0; lc_value_in = '0; cl_in = 1'b0; cache_line_in = '0;
        repeat (3) @(negedge clk_in);
        check_all_zero("reset");
        rst_N_in = 1'b0;
        #1;
        check_eq("ready_after_reset", hc_ready_out, 1'b1);
        cs_in = 1'b0;
        #1;
        check_eq("ready_cs_low", hc_ready_out, 1'b0);
        cs_in = 1'b1;

        issue(64'h0, 1'b0, '0, 64'h0123456789ABCDEF, 1'b1, "cold0");
        lc_req(1'b0, 64'h0, 0, '0, "cold0");
        fill(64'h0, 64'h0123456789ABCDEF, 1'b0, '0, "cold0");
        drain("cold0");
        issue(64'h0, 1'b0, '0, 64'h0123456789ABCDEF, 1'b0, "hit0");
        drain("hit0");

        issue(64'h4000, 1'b0, '0, 64'h1111111111111111, 1'b1, "ld4000");
        lc_req(1'b0, 64'h4000, 0, '0, "ld4000");
        fill(64'h4000, 64'h1111111111111111, 1'b0, '0, "ld4000");
        drain("ld4000");
        issue(64'h34000, 1'b0, '0, 64'h2222222222222222, 1'b1, "ld34000");
        lc_req(1'b0, 64'h34000, 0, '0, "ld34000");
        fill(64'h34000, 64'hBAD0BAD0BAD0BAD0, 1'b1, mk_line(64'h2222222222222222), "ld34000");
        drain("ld34000");
        issue(64'h44000, 1'b0, '0, 64'h3333333333333333, 1'b1, "ld44000");
        lc_req(1'b0, 64'h44000, 0, '0, "ld44000");
        fill(64'h44000, 64'hBAD0BAD0BAD0BAD0, 1'b1, mk_line(64'h3333333333333333), "ld44000");
        drain("ld44000");

        issue(64'h54, 1'b0, '0, 64'hDEADBEEFDEADBEEF, 1'b1, "ld54");
        lc_req(1'b0, 64'h40, 0, '0, "ld54");
        fill(64'h54, 64'hDEADBEEFDEADBEEF, 1'b0, '0, "ld54");
        drain("ld54");
        issue(64'h44008, 1'b0, '0, 64'h3333333333333334, 1'b0, "hit44008");
        drain("hit44008");

        issue(64'h0, 1'b1, 64'hFEDCBA9876543210, 64'hFEDCBA9876543210, 1'b1, "st0");
        lc_req(1'b0, 64'h0, 0, '0, "st0");
        fill(64'h0, 64'h0, 1'b0, '0, "st0");
        drain("st0");
        issue(64'h0, 1'b0, '0, 64'hFEDCBA9876543210, 1'b0, "ld0_after_st");
        drain("ld0_after_st");

        issue(64'h4000, 1'b0, '0, 64'h4444444444444444, 1'b1, "reld4000");
        lc_req(1'b0, 64'h4000, 0, '0, "reld4000");
        fill(64'h4000, 64'h4444444444444444, 1'b0, '0, "reld4000");
        drain("reld4000");
        issue(64'h34000, 1'b0, '0, 64'h5555555555555555, 1'b1, "evict_dirty");
        lc_req(1'b1, 64'h0, 0, 64'hFEDCBA9876543210, "evict_dirty_wb");
        lc_req(1'b0, 64'h34000, 0, '0, "evict_dirty_rd");
        fill(64'h34000, 64'h5555555555555555, 1'b0, '0, "evict_dirty");
        drain("evict_dirty");

        issue(64'h54, 1'b1, 64'hA5A5A5A5A5A5A5A5, 64'hA5A5A5A5A5A5A5A5, 1'b0, "st54");
        drain("st54");
        @(negedge clk_in);
        flush_in = 1'b1;
        #1;
        check_eq("flush_blocks_ready", hc_ready_out, 1'b0);
        @(posedge clk_in);
        #1;
        flush_in = 1'b0;
        lc_req(1'b1, 64'h40, 2, 64'hA5A5A5A5A5A5A5A5, "flush_wb");
        guard = 0;
        while (!hc_ready_out && guard < 300) begin
            @(negedge clk_in);
            guard++;
        end
        check_eq("flush_done_idle", hc_ready_out, 1'b1);
        issue(64'h54, 1'b0, '0, 64'h7777777777777777, 1'b1, "ld54_after_flush");
        lc_req(1'b0, 64'h40, 0, '0, "ld54_after_flush");
        fill(64'h50, 64'h7777777777777777, 1'b0, '0, "ld54_after_flush");
        drain("ld54_after_flush");

        issue(64'h0, 1'b0, '0, 64'h0, 1'b1, "rst_mid");
        lc_req(1'b0, 64'h0, 0, '0, "rst_mid");
        @(negedge clk_in);
        check_eq("rst_mid_fill_wait", lc_ready_out, 1'b1);
        rst_N_in = 1'b1;
        #1;
        check_all_zero("rst_mid");
        sb_q.delete();
        repeat (2) @(negedge clk_in);
        rst_N_in = 1'b0;
        issue(64'h0, 1'b0, '0, 64'h9999999999999999, 1'b1, "ld0_after_rst");
        lc_req(1'b0, 64'h0, 0, '0, "ld0_after_rst");
        fill(64'h0, 64'h9999999999999999, 1'b0, '0, "ld0_after_rst");
        drain("ld0_after_rst");

        repeat (2) @(negedge clk_in);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/generic_cache.md
Name: generic_cache

Overview:
- Parameterised set-associative, write-back, write-allocate cache with LRU replacement, one request outstanding at a time.
- Sits between a higher-level requester (hc_*, 64-bit word interface) and a lower level (lc_*, 512-bit line write-back plus word/line fill).
- Misses are filled from the lower level, then the original request is replayed internally and answered.

Parameters:
- W, 64, address and data word width (bits).
- C, 8192, capacity in bytes.
- B, 64, line size in bytes (512-bit line).
- A, 2, associativity. Derived: 64 sets, offset [5:0], word select [5:3], index [11:6], tag [W-1:12].

Ports:
- clk_in  in  1  clock, all state on rising edge.
- rst_N_in  in  1  reset, asynchronous, active-high (1 = reset, despite the name).
- cs_in  in  1  chip select; when 0 no new request is accepted.
- flush_in  in  1  when 1 in IDLE: write back all dirty lines, then invalidate all lines.
- hc_valid_in / hc_ready_out  in/out  1  request handshake; accepted on an edge where both are 1.
- hc_addr_in  in  W  byte address.
- hc_value_in  in  W  store data.
- hc_we_in  in  1  1 = store, 0 = load.
- hc_valid_out / hc_ready_in  out/in  1  response handshake.
- hc_we_out  out  1  echoes request type.
- hc_addr_out  out  W  echoes request address.
- hc_value_out  out  W  load data; on a store, the stored word.
- lc_valid_out / lc_ready_in  out/in  1  lower-level request handshake.
- lc_addr_out  out  W  line-aligned address (low 6 bits 0).
- lc_value_out  out  512  victim line on write-back, else 0.
- we_out  out  1  1 = write-back, 0 = line read.
- lc_valid_in / lc_ready_out  in/out  1  fill handshake.
- lc_addr_in  in  W  fill address; [5:3] selects the word.
- lc_value_in  in  W  fill word.
- cl_in  in  1  1 = fill is a full line from cache_line_in.
- cache_line_in  in  512  full-line fill data.

Behaviour:
- Reset: all outputs 0; all valid, dirty and LRU bits cleared; state IDLE. Reset mid-transaction abandons it.
- hc_ready_out = (state==IDLE) && cs_in && !flush_in.
- Tag lookup is combinational on hc_addr_in; the outcome is registered on the accept edge.
- Hit (accept edge E):
  - Load: at E, hc_valid_out=1 with the line word; LRU updated.
  - Store: word written, dirty set, response with hc_we_out=1.
  - State RESP holds the response until hc_valid_out && hc_ready_in, then returns to IDLE.
- Miss: victim = invalid way (lowest index first), else the LRU way.
  - Victim dirty: at E go WB (lc_valid_out=1, we_out=1, lc_addr_out = victim line address, lc_value_out = victim line). Hold until lc_ready_in, then FILL_REQ.
  - Victim clean: at E go directly to FILL_REQ, with lc_valid_out=1 visible from E.
  - FILL_REQ: lc_valid_out=1, we_out=0, lc_addr_out = requested line. Hold until lc_ready_in, then FILL_WAIT.
  - FILL_WAIT: lc_ready_out=1. On lc_valid_in:
    - cl_in=1: install cache_line_in.
    - cl_in=0: install a zero line with lc_value_in at word lc_addr_in[5:3].
    - Install sets valid, clears dirty, writes the pending tag into the victim way. lc_addr_in tag/index are ignored.
  - On the fill edge, replay the pending request (store merges the word and sets dirty), update LRU, assert hc_valid_out, go to RESP.
- LRU: one bit per set for A=2 (pseudo-LRU tree generally). Touched on hit and on fill.
- flush_in in IDLE: state FLUSH walks sets/ways, issues a WB handshake per dirty line, clears all valid bits, then returns to IDLE.
- Simultaneous lc_valid_in outside FILL_WAIT: ignored.
- cs_in deassert while busy: the current transaction still completes.

Decomposition:
- Shared package: W/B/A defaults, derived OFFSET/INDEX/TAG widths, state enum (IDLE, RESP, WB, FILL_REQ, FILL_WAIT, FLUSH), line typedef (logic [511:0]).
- One sub-module: cache_tag_array (valid/dirty/tag/LRU storage, combinational hit/way/victim lookup).

Test Plan:
- Cold load 0x0: lc_valid_out=1, we_out=0, lc_addr_out=0x0. Fill 0x0123456789ABCDEF at 0x0 -> hc_valid_out with that value; re-request 0x0 hits with the same value and no lc_valid_out.
- Loads 0x4000, 0x34000, 0x44000 (all set 0, 2 ways), each filled with a distinct value -> each misses, each returns its fill value; 0x0 and 0x4000 are evicted (LRU).
- Load 0x54 (set 1), fill 0xDEADBEEFDEADBEEF at 0x54 -> word 2 returned; set 0 untouched.
- Store 0xFEDCBA9876543210 to 0x0 -> write-allocate miss: lc_valid_out on the accept edge, clean victim 0x34000 (no WB). Fill 0 -> store merged; then load 0x0 returns 0xFEDCBA9876543210.
- Load 0x4000 -> evicts the LRU way (0x44000, clean) with a read miss. A following access that evicts the now-dirty 0x0 line -> WB with we_out=1, lc_addr_out=0x0, lc_value_out word0=0xFEDCBA9876543210, then the read.
- Assert rst_N_in=1 during FILL_WAIT -> all outputs 0 immediately; next load 0x0 misses.
